// File: rtl/game_countdown_timer_pkg.sv
// Shared types and helpers for the EatUp round countdown timer.
// Holds the state encoding, BCD digit types and BCD conversion/decrement.
package game_timer_pkg;

    localparam int MAX_MINSEC = 59;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    typedef logic [3:0] bcd_t;

    typedef struct packed {
        bcd_t tens;
        bcd_t ones;
    } bcd2_t;

    typedef struct packed {
        bcd_t min_tens;
        bcd_t min_ones;
        bcd_t sec_tens;
        bcd_t sec_ones;
    } mmss_t;

    function automatic int clamp59(input int v);
        return (v < 0 || v > MAX_MINSEC) ? MAX_MINSEC : v;
    endfunction

    function automatic bcd2_t to_bcd2(input int dec);
        bcd2_t r;
        r.tens = 4'(dec / 10);
        r.ones = 4'(dec % 10);
        return r;
    endfunction

    // One-second BCD borrow chain; saturates at 00:00.
    function automatic mmss_t mmss_dec(input mmss_t v);
        mmss_t r;
        r = v;
        if (v == '0) begin
            return v;
        end
        if (v.sec_ones != 4'd0) begin
            r.sec_ones = v.sec_ones - 4'd1;
        end else begin
            r.sec_ones = 4'd9;
            if (v.sec_tens != 4'd0) begin
                r.sec_tens = v.sec_tens - 4'd1;
            end else begin
                r.sec_tens = 4'd5;
                if (v.min_ones != 4'd0) begin
                    r.min_ones = v.min_ones - 4'd1;
                end else begin
                    r.min_ones = 4'd9;
                    r.min_tens = v.min_tens - 4'd1;
                end
            end
        end
        return r;
    endfunction

    function automatic logic mmss_le1(input mmss_t v);
        return (v[15:1] == '0);
    endfunction

endpackage

// File: rtl/game_countdown_timer_if.sv
// Command and display bundle between game controller and timer.
// master: drives tick_in/start/pause/clear; slave: drives digits and status.
interface game_countdown_timer_if;
    import game_timer_pkg::*;

    logic tick_in;
    logic start;
    logic pause;
    logic clear;
    bcd_t min_tens;
    bcd_t min_ones;
    bcd_t sec_tens;
    bcd_t sec_ones;
    logic running;
    logic time_up;
    logic time_up_pulse;

    modport master (
        output tick_in, start, pause, clear,
        input  min_tens, min_ones, sec_tens, sec_ones,
        input  running, time_up, time_up_pulse
    );

    modport slave (
        input  tick_in, start, pause, clear,
        output min_tens, min_ones, sec_tens, sec_ones,
        output running, time_up, time_up_pulse
    );

endinterface

// File: rtl/game_countdown_timer_tick_edge_detect.sv
// Synchronises a slow divider square wave and emits a one-cycle rising-edge tick.
// Ports: clk, rst_n (sync, active-low), tick_in (data), tick (pulse).
module tick_edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic tick_in,
    output logic tick
);

    logic q1;
    logic q2;
    logic q3;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q1 <= 1'b0;
            q2 <= 1'b0;
            q3 <= 1'b0;
        end else begin
            q1 <= tick_in;
            q2 <= q1;
            q3 <= q2;
        end
    end

    assign tick = q2 & ~q3;

endmodule

// File: rtl/game_countdown_timer.sv
// Round countdown timer: BCD mm:ss down-counter with IDLE/RUN/PAUSE/DONE FSM.
// Ports: clk, rst_n (sync, active-low), bus (slave side of timer interface).
module game_countdown_timer
    import game_timer_pkg::*;
#(
    parameter int START_MIN = 1,
    parameter int START_SEC = 30
) (
    input  logic                    clk,
    input  logic                    rst_n,
    game_countdown_timer_if.slave   bus
);

    localparam logic [1:0] S_IDLE  = ST_IDLE;
    localparam logic [1:0] S_RUN   = ST_RUN;
    localparam logic [1:0] S_PAUSE = ST_PAUSE;
    localparam logic [1:0] S_DONE  = ST_DONE;

    localparam int    MIN_C     = clamp59(START_MIN);
    localparam int    SEC_C     = clamp59(START_SEC);
    localparam bcd2_t START_M   = to_bcd2(MIN_C);
    localparam bcd2_t START_S   = to_bcd2(SEC_C);
    localparam mmss_t START_VAL = {START_M, START_S};
    localparam logic  START_Z   = (MIN_C == 0) && (SEC_C == 0);

    logic       tick;
    logic [1:0] state_q;
    logic [1:0] state_d;
    mmss_t      dig_q;
    mmss_t      dig_d;
    logic       pulse_d;
    logic       pulse_q;
    logic       run_q;
    logic       up_q;

    tick_edge_detect u_tick (
        .clk     (clk),
        .rst_n   (rst_n),
        .tick_in (bus.tick_in),
        .tick    (tick)
    );

    always_comb begin
        state_d = state_q;
        dig_d   = dig_q;
        pulse_d = 1'b0;
        if (bus.clear) begin
            state_d = S_IDLE;
            dig_d   = START_VAL;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        if (START_Z) begin
                            state_d = S_DONE;
                            pulse_d = 1'b1;
                        end else begin
                            state_d = S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    // pause wins over a coincident tick
                    if (bus.pause) begin
                        state_d = S_PAUSE;
                    end else if (tick) begin
                        dig_d = mmss_dec(dig_q);
                        if (mmss_le1(dig_q)) begin
                            state_d = S_DONE;
                            pulse_d = 1'b1;
                        end
                    end
                end
                S_PAUSE: begin
                    if (bus.start) begin
                        state_d = S_RUN;
                    end
                end
                S_DONE: begin
                    // restart; a 00:00 round has nothing to run
                    if (bus.start) begin
                        dig_d   = START_VAL;
                        state_d = START_Z ? S_DONE : S_RUN;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            dig_q   <= START_VAL;
            pulse_q <= 1'b0;
            run_q   <= 1'b0;
            up_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            dig_q   <= dig_d;
            pulse_q <= pulse_d;
            run_q   <= (state_d == S_RUN);
            up_q    <= (state_d == S_DONE);
        end
    end

    assign bus.min_tens      = dig_q.min_tens;
    assign bus.min_ones      = dig_q.min_ones;
    assign bus.sec_tens      = dig_q.sec_tens;
    assign bus.sec_ones      = dig_q.sec_ones;
    assign bus.running       = run_q;
    assign bus.time_up       = up_q;
    assign bus.time_up_pulse = pulse_q;

endmodule

// File: tb/tb_game_countdown_timer.sv
// Self-checking bench: four timers with different start values share stimulus.
// Model counts whole seconds and tracks mode; outputs compared every cycle.
module tb_game_countdown_timer;

    localparam int N = 4;
    localparam int SMIN [N] = '{1, 0, 10, 0};
    localparam int SSEC [N] = '{30, 2, 0, 0};

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_DONE  = 3;

    logic clk = 1'b0;
    logic rst_n;
    logic tick_in;
    logic start;
    logic pause;
    logic clear;

    logic [N-1:0][15:0] dig;
    logic [N-1:0][2:0]  flg;

    int tests = 0;
    int fails = 0;
    int b_pulses = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        game_countdown_timer_if bus ();
        assign bus.tick_in = tick_in;
        assign bus.start   = start;
        assign bus.pause   = pause;
        assign bus.clear   = clear;

        game_countdown_timer #(
            .START_MIN (SMIN[g]),
            .START_SEC (SSEC[g])
        ) dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bus.slave)
        );

        assign dig[g] = {bus.min_tens, bus.min_ones,
                         bus.sec_tens, bus.sec_ones};
        assign flg[g] = {bus.running, bus.time_up,
                         bus.time_up_pulse};
    end

    // ---------------- behavioural model ----------------
    int m_secs [N];
    int m_st   [N];
    bit m_pulse [N];
    bit s1 = 0;
    bit s2 = 0;
    bit s3 = 0;
    bit m_tick;
    bit armed = 0;

    function automatic int start_total(input int i);
        return SMIN[i] * 60 + SSEC[i];
    endfunction

    function automatic logic [15:0] exp_dig(input int s);
        int m;
        int c;
        m = s / 60;
        c = s % 60;
        return {4'(m / 10), 4'(m % 10), 4'(c / 10), 4'(c % 10)};
    endfunction

    function automatic logic [2:0] exp_flg(input int st, input bit p);
        return {st == M_RUN, st == M_DONE, p};
    endfunction

    always @(posedge clk) begin
        // tick seen at this edge: tick_in high two edges ago, low three ago
        m_tick = s2 & ~s3;
        if (!rst_n) begin
            s1 = 0;
            s2 = 0;
            s3 = 0;
            for (int i = 0; i < N; i++) begin
                m_secs[i]  = start_total(i);
                m_st[i]    = M_IDLE;
                m_pulse[i] = 0;
            end
        end else begin
            s3 = s2;
            s2 = s1;
            s1 = tick_in;
            for (int i = 0; i < N; i++) begin
                m_pulse[i] = 0;
                if (clear) begin
                    m_st[i]   = M_IDLE;
                    m_secs[i] = start_total(i);
                end else if (m_st[i] == M_IDLE) begin
                    if (start) begin
                        if (start_total(i) == 0) begin
                            m_st[i]    = M_DONE;
                            m_pulse[i] = 1;
                        end else begin
                            m_st[i] = M_RUN;
                        end
                    end
                end else if (m_st[i] == M_RUN) begin
                    if (pause) begin
                        m_st[i] = M_PAUSE;
                    end else if (m_tick) begin
                        if (m_secs[i] > 0) m_secs[i] = m_secs[i] - 1;
                        if (m_secs[i] == 0) begin
                            m_st[i]    = M_DONE;
                            m_pulse[i] = 1;
                        end
                    end
                end else if (m_st[i] == M_PAUSE) begin
                    if (start) m_st[i] = M_RUN;
                end else begin
                    if (start) begin
                        m_secs[i] = start_total(i);
                        m_st[i] = (m_secs[i] == 0) ? M_DONE : M_RUN;
                    end
                end
            end
        end
        armed = 1;
    end

    always @(negedge clk) begin
        if (armed) begin
            for (int i = 0; i < N; i++) begin
                tests++;
                if (dig[i] !== exp_dig(m_secs[i])) begin
                    fails++;
                    $display("FAIL model_digits[%0d] t=%0t got %h want %h",
                             i, $time, dig[i], exp_dig(m_secs[i]));
                end
                tests++;
                if (flg[i] !== exp_flg(m_st[i], m_pulse[i])) begin
                    fails++;
                    $display("FAIL model_flags[%0d] t=%0t got %b want %b",
                             i, $time, flg[i],
                             exp_flg(m_st[i], m_pulse[i]));
                end
            end
            if (flg[1][0] === 1'b1) b_pulses++;
        end
    end

    // ---------------- literal checks ----------------
    task automatic lit(input string nm, input logic [15:0] got,
                       input logic [15:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got %h want %h", nm, got, exp);
        end
    endtask

    task automatic send_tick(input int n);
        for (int i = 0; i < n; i++) begin
            tick_in = 1'b1;
            repeat (3) @(negedge clk);
            tick_in = 1'b0;
            repeat (2) @(negedge clk);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        rst_n   = 1'b0;
        tick_in = 1'b0;
        start   = 1'b0;
        pause   = 1'b0;
        clear   = 1'b0;
        repeat (2) @(negedge clk);
        lit("rst_a_dig", dig[0], 16'h0130);
        lit("rst_a_flg", 16'(flg[0]), 16'(3'b000));
        lit("rst_c_dig", dig[2], 16'h1000);
        lit("rst_d_dig", dig[3], 16'h0000);

        rst_n = 1'b1;
        @(negedge clk);
        pulse_start();
        lit("start_a_flg", 16'(flg[0]), 16'(3'b100));
        lit("start_d_flg", 16'(flg[3]), 16'(3'b011));
        @(negedge clk);
        lit("d_pulse_1cyc", 16'(flg[3]), 16'(3'b010));

        b_pulses = 0;
        tick_in = 1'b1;
        repeat (2) @(negedge clk);
        lit("lat_k1_hold", dig[0], 16'h0130);
        @(negedge clk);
        lit("lat_k2_dec", dig[0], 16'h0129);
        tick_in = 1'b0;
        repeat (2) @(negedge clk);
        send_tick(2);
        lit("a_0127", dig[0], 16'h0127);
        lit("a_running", 16'(flg[0]), 16'(3'b100));
        lit("c_0959_0957", dig[2], 16'h0957);
        lit("b_zero", dig[1], 16'h0000);
        lit("b_done", 16'(flg[1]), 16'(3'b010));
        lit("b_pulse_cnt", 16'(b_pulses), 16'd1);
        send_tick(2);
        lit("b_hold_zero", dig[1], 16'h0000);
        lit("b_pulse_cnt2", 16'(b_pulses), 16'd1);

        tick_in = 1'b1;
        repeat (2) @(negedge clk);
        pause = 1'b1;
        @(negedge clk);
        pause   = 1'b0;
        tick_in = 1'b0;
        lit("pause_drop", dig[0], 16'h0125);
        lit("pause_flg", 16'(flg[0]), 16'(3'b000));
        repeat (2) @(negedge clk);
        send_tick(5);
        lit("pause_hold", dig[0], 16'h0125);

        pulse_start();
        lit("b_restart_dig", dig[1], 16'h0002);
        lit("b_restart_flg", 16'(flg[1]), 16'(3'b100));
        send_tick(1);
        lit("resume_a", dig[0], 16'h0124);
        lit("resume_b", dig[1], 16'h0001);
        lit("resume_c", dig[2], 16'h0954);

        clear = 1'b1;
        start = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        start = 1'b0;
        lit("clear_a_dig", dig[0], 16'h0130);
        lit("clear_a_flg", 16'(flg[0]), 16'(3'b000));
        lit("clear_c_dig", dig[2], 16'h1000);

        pulse_start();
        send_tick(1);
        lit("after_clear", dig[0], 16'h0129);
        tick_in = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        lit("midrst_dig", dig[0], 16'h0130);
        lit("midrst_flg", 16'(flg[0]), 16'(3'b000));
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        tick_in = 1'b0;
        repeat (2) @(negedge clk);
        lit("rst_tick_idle", dig[0], 16'h0130);

        pulse_start();
        send_tick(540);
        lit("c_0100", dig[2], 16'h0100);
        send_tick(1);
        lit("c_0059", dig[2], 16'h0059);

        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 3) == 0) tick_in = ~tick_in;
            start = ($urandom_range(0, 15) == 0);
            pause = ($urandom_range(0, 23) == 0);
            clear = ($urandom_range(0, 79) == 0);
            rst_n = ($urandom_range(0, 299) != 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        start = 1'b0;
        pause = 1'b0;
        clear = 1'b0;
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/game_countdown_timer.md
# game_countdown_timer

Round countdown timer for the EatUp game. It sits directly downstream of the 1-second clock divider. It samples the divider's slow square wave in the system clock domain and turns each rising edge into a one-cycle tick. It counts a BCD mm:ss value down from a configured start time and reports time-up to the game controller. Its four BCD digits feed the seven-segment display driver.

## Interface
- START_MIN, default 1: initial minutes, decimal 0–59.
- START_SEC, default 30: initial seconds, decimal 0–59.
- clk  in  1  system clock; the only clock.
- rst_n  in  1  synchronous reset, active-low.
- tick_in  in  1  slow square wave from the 1-second divider. Treated as data, never used as a clock.
- start  in  1  level; sampled every clk.
- pause  in  1  level; sampled every clk.
- clear  in  1  level; sampled every clk.
- min_tens  out  4  BCD digit, 0–5.
- min_ones  out  4  BCD digit, 0–9.
- sec_tens  out  4  BCD digit, 0–5.
- sec_ones  out  4  BCD digit, 0–9.
- running  out  1  high while in RUN.
- time_up  out  1  level; high while in DONE.
- time_up_pulse  out  1  one-cycle pulse on entry to DONE.

## Operation
- Tick detection:
  - Three-flop chain q1 <= tick_in, q2 <= q1, q3 <= q2.
  - tick = q2 & ~q3.
  - Only rising edges of tick_in count. Falling edges are ignored.
- States: IDLE, RUN, PAUSE, DONE.
- Command priority, every cycle: clear > pause > start > tick.
- clear, any state: go to IDLE and reload the digits with START_MIN:START_SEC.
- IDLE:
  - start -> RUN.
  - If the start value is 00:00, start goes directly to DONE and pulses time_up_pulse.
  - pause and tick are ignored.
- RUN:
  - pause -> PAUSE. A tick in the same cycle is dropped.
  - start is ignored.
  - tick decrements mm:ss by one second.
- PAUSE:
  - start -> RUN.
  - tick is ignored; the digits hold.
- DONE:
  - start -> reload the digits and go to RUN. This is a restart.
  - pause and tick are ignored. The digits hold at 00:00.
- Decrement rules (BCD borrow chain):
  - sec_ones 0 -> 9 and borrow from sec_tens.
  - sec_tens 0 -> 5 and borrow from min_ones.
  - min_ones 0 -> 9 and borrow from min_tens.
  - Example: 10:00 -> 09:59.
- Reaching zero:
  - A tick at 00:01 writes 00:00, enters DONE and pulses time_up_pulse in the same update.
  - The counter never wraps below 00:00.
- Parameters outside 0–59 are clamped to 59 at elaboration.

## Timing
- Reset values:
  - Digits equal the BCD of START_MIN:START_SEC.
  - State IDLE.
  - running = 0, time_up = 0, time_up_pulse = 0.
  - q1, q2, q3 = 0.
  - A tick_in that is already high at reset release produces one tick two edges later. This is acceptable; in IDLE it is ignored.
- Tick latency:
  - tick_in rises before clk edge k.
  - tick is asserted during the cycle after edge k+1.
  - The digits change at edge k+2.
- Command latency: start, pause and clear take effect at the first clk edge that samples them high. State and outputs update at that edge.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- time_up_pulse:
  - Exactly one cycle wide.
  - Not re-issued while the block remains in DONE.
- Reset mid-count restores the reset values at the next clk edge. Any pending tick in the q chain is discarded, because the q flops reset too.

## Structure
- Package game_timer_pkg holds:
  - the state enum (IDLE, RUN, PAUSE, DONE, 2-bit);
  - the BCD digit type (4-bit);
  - the constant MAX_MINSEC = 59;
  - the function to_bcd2(decimal), which returns tens and ones digits.
- Sub-module tick_edge_detect contains the three-flop chain and the rising-edge pulse. It is reusable for the other divider outputs.
- Top level: FSM plus BCD down-counter, with the clear/pause/start priority decode.

## Test plan
- Reset with START 1:30, then start and 3 tick_in rising edges -> digits 01:27, running = 1; each change lands 2 clk after the edge was sampled.
- START 0:02, start, 2 ticks -> 00:00, time_up_pulse high for exactly 1 cycle, time_up held; further ticks leave 00:00.
- Load 10:00 (START_MIN = 10, START_SEC = 0), start, 1 tick -> 09:59. At 01:00, 1 tick -> 00:59.
- RUN, pause asserted in the same cycle as tick -> digits unchanged, state PAUSE. 5 ticks in PAUSE -> unchanged. start, 1 tick -> decrement by 1.
- clear and start high together in RUN -> IDLE, digits = START. rst_n low mid-count -> reset values on the next edge.
- DONE, then start -> digits reload to START, running = 1, time_up = 0. START 0:00 with start -> DONE immediately, one pulse.
